// File: rtl/davinci_sched_pkg.sv
// davinci_sched_pkg: opcode, field-position and state definitions for the dispatch scheduler.
package davinci_sched_pkg;
    typedef enum logic [1:0] {
        OP_GEMV = 2'b00,
        OP_VVT  = 2'b01,
        OP_SYNC = 2'b10,
        OP_EOV  = 2'b11
    } opcodeT;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 30;
    localparam int DEP_BIT = 29;
    typedef enum logic [1:0] {
        DISPATCH   = 2'b00,
        VVT_WAIT   = 2'b01,
        WAIT_DRAIN = 2'b10
    } stateT;
endpackage

// File: rtl/gemv_drain_counter.sv
// gemv_drain_counter: loadable saturating down-counter tracking GEMV results still in flight.
module gemv_drain_counter #(
    parameter int GEMV_LATENCY = 40,
    parameter int CNT_WIDTH = $clog2(GEMV_LATENCY + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 zero
);
    assign zero = count == '0;

    // A load always wins over the decrement, so a reload restarts the full drain window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            count <= '0;
        else if (load)
            count <= CNT_WIDTH'(GEMV_LATENCY);
        else if (!zero)
            count <= count - CNT_WIDTH'(1);
    end
endmodule

// File: rtl/davinci_dispatch_sched.sv
// davinci_dispatch_sched: pops FIFO-in words and dispatches them to the GEMV and VVT arrays,
// holding dependent VVT and SYNC words until the GEMV pipeline has drained.
module davinci_dispatch_sched
    import davinci_sched_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int GEMV_INSTR_WIDTH = 28,
    parameter int VVT_INSTR_WIDTH = 28,
    parameter int GEMV_LATENCY = 40,
    parameter int CNT_WIDTH = $clog2(GEMV_LATENCY + 1)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [INSTR_WIDTH-1:0]      instruction,
    input  logic                        instructionValid,
    output logic                        instructionNext,
    output logic [GEMV_INSTR_WIDTH-1:0] gemv_instruction,
    output logic                        gemv_valid,
    output logic [VVT_INSTR_WIDTH-1:0]  vvt_instruction,
    output logic                        vvt_valid,
    input  logic                        vvt_next,
    output logic                        eov_marker,
    output logic [CNT_WIDTH-1:0]        gemv_pending,
    output logic                        busy
);
    stateT  state;
    opcodeT opc;
    logic   dep, cntZero, accept, canDispatch, ready, popGemv, popVvt, unusedBits;

    assign opc = opcodeT'(instruction[OPC_MSB:OPC_LSB]);
    assign dep = instruction[DEP_BIT];
    assign unusedBits = ^instruction;
    assign accept = vvt_valid && vvt_next;
    // The accept cycle of VVT_WAIT behaves as DISPATCH so VVT words can stream at one per cycle.
    assign canDispatch = state == DISPATCH || (state == VVT_WAIT && accept);
    assign ready = (opc == OP_VVT && dep) ? cntZero :
                   (opc == OP_SYNC) ? cntZero && !vvt_valid : 1'b1;
    assign instructionNext = rstn && canDispatch && instructionValid && ready;
    assign popGemv = instructionNext && opc == OP_GEMV;
    assign popVvt = instructionNext && opc == OP_VVT;
    assign busy = state != DISPATCH || vvt_valid || !cntZero;

    gemv_drain_counter #(
        .GEMV_LATENCY(GEMV_LATENCY),
        .CNT_WIDTH(CNT_WIDTH)
    ) drainCounter (
        .clk(clk),
        .rstn(rstn),
        .load(popGemv),
        .count(gemv_pending),
        .zero(cntZero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= DISPATCH;
            gemv_instruction <= '0;
            gemv_valid <= 1'b0;
            vvt_instruction <= '0;
            vvt_valid <= 1'b0;
            eov_marker <= 1'b0;
        end else begin
            gemv_valid <= popGemv;
            eov_marker <= instructionNext && opc == OP_EOV;
            vvt_valid <= popVvt || (vvt_valid && !vvt_next);
            if (popGemv)
                gemv_instruction <= instruction[GEMV_INSTR_WIDTH-1:0];
            if (popVvt)
                vvt_instruction <= instruction[VVT_INSTR_WIDTH-1:0];
            // A blocked head stays in the FIFO; WAIT_DRAIN re-evaluates the same word each cycle.
            if (canDispatch)
                state <= !instructionValid ? DISPATCH :
                         instructionNext ? (popVvt ? VVT_WAIT : DISPATCH) : WAIT_DRAIN;
            else if (state == WAIT_DRAIN && ready)
                state <= DISPATCH;
        end
    end
endmodule

// File: tb/tb_davinci_dispatch_sched.sv
// tb_davinci_dispatch_sched: vector table plus corner-case sequences, with a FIFO model and
// payload scoreboards fed at pop time and drained when the DUT issues.
module tb_davinci_dispatch_sched;
    localparam int LAT = 40;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instruction;
    logic        instructionValid;
    logic        instructionNext;
    logic [27:0] gemv_instruction;
    logic        gemv_valid;
    logic [27:0] vvt_instruction;
    logic        vvt_valid;
    logic        vvt_next;
    logic        eov_marker;
    logic [5:0]  gemv_pending;
    logic        busy;

    davinci_dispatch_sched dut (
        .clk(clk),
        .rstn(rstn),
        .instruction(instruction),
        .instructionValid(instructionValid),
        .instructionNext(instructionNext),
        .gemv_instruction(gemv_instruction),
        .gemv_valid(gemv_valid),
        .vvt_instruction(vvt_instruction),
        .vvt_valid(vvt_valid),
        .vvt_next(vvt_next),
        .eov_marker(eov_marker),
        .gemv_pending(gemv_pending),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        expNext;
        logic        expGv;
        logic        expVv;
        logic        expEov;
        logic [5:0]  expPend;
        logic        expBusy;
    } vecT;

    int          nChecks = 0;
    int          nFail = 0;
    logic [31:0] fifo[$];
    logic [27:0] gemvQ[$];
    logic [27:0] vvtQ[$];
    int          eovQ[$];
    logic        nextLog, popped, vvSample;
    logic [1:0]  lastOpc;
    logic [5:0]  pendSample;
    vecT         vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        instruction = fifo.size() > 0 ? fifo[0] : 32'h0;
        instructionValid = fifo.size() > 0;
    endtask

    task automatic tick();
        logic p, acc;
        logic [31:0] w;
        @(negedge clk);
        p = instructionNext;
        acc = vvt_valid && vvt_next;
        nextLog = p;
        pendSample = gemv_pending;
        vvSample = vvt_valid;
        if (!rstn)
            chk("no_pop_in_reset", {31'b0, p}, 32'd0);
        if (vvt_valid) begin
            if (vvtQ.size() == 0)
                chk("vvt_unexpected", {31'b0, vvt_valid}, 32'd0);
            else
                chk("vvt_payload", {4'b0, vvt_instruction}, {4'b0, vvtQ[0]});
        end
        @(posedge clk);
        if (acc && vvtQ.size() > 0)
            void'(vvtQ.pop_front());
        popped = p;
        lastOpc = 2'b00;
        if (p) begin
            w = fifo.pop_front();
            lastOpc = w[31:30];
            if (w[31:30] == 2'b00) gemvQ.push_back(w[27:0]);
            if (w[31:30] == 2'b01) vvtQ.push_back(w[27:0]);
            if (w[31:30] == 2'b11) eovQ.push_back(1);
        end
        #1;
        drive();
        if (gemv_valid) begin
            if (gemvQ.size() == 0)
                chk("gemv_unexpected", {31'b0, gemv_valid}, 32'd0);
            else
                chk("gemv_payload", {4'b0, gemv_instruction}, {4'b0, gemvQ.pop_front()});
        end
        chk("gemv_issue_latency", gemvQ.size(), 32'd0);
        chk("eov_pulse", {31'b0, eov_marker}, eovQ.size());
        gemvQ.delete();
        eovQ.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        vvt_next = 1'b1;
        while ((busy || fifo.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int n, vvHigh;
        logic [27:0] held;
        vecs[0] = '{32'h0ABCDEF1, 1, 1, 0, 0, 6'd40, 1};
        vecs[1] = '{32'h41234567, 1, 0, 1, 0, 6'd0, 1};
        vecs[2] = '{32'h6765432A, 1, 0, 1, 0, 6'd0, 1};
        vecs[3] = '{32'h80000001, 1, 0, 0, 0, 6'd0, 0};
        vecs[4] = '{32'hC0000005, 1, 0, 0, 1, 6'd0, 0};
        vecs[5] = '{32'h4FFFFFFF, 1, 0, 1, 0, 6'd0, 1};
        vecs[6] = '{32'h0FFFFFFF, 1, 1, 0, 0, 6'd40, 1};

        rstn = 1'b0;
        vvt_next = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gemv_valid", {31'b0, gemv_valid}, 32'd0);
        chk("rst_vvt_valid", {31'b0, vvt_valid}, 32'd0);
        chk("rst_eov", {31'b0, eov_marker}, 32'd0);
        chk("rst_pending", {26'b0, gemv_pending}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_next", {31'b0, instructionNext}, 32'd0);
        rstn = 1'b1;

        // single-word dispatch from idle
        for (int i = 0; i < 7; i++) begin
            vvt_next = 1'b0;
            fifo.push_back(vecs[i].word);
            drive();
            tick();
            chk("vec_next", {31'b0, nextLog}, {31'b0, vecs[i].expNext});
            chk("vec_gemv_valid", {31'b0, gemv_valid}, {31'b0, vecs[i].expGv});
            chk("vec_vvt_valid", {31'b0, vvt_valid}, {31'b0, vecs[i].expVv});
            chk("vec_eov", {31'b0, eov_marker}, {31'b0, vecs[i].expEov});
            chk("vec_pending", {26'b0, gemv_pending}, {26'b0, vecs[i].expPend});
            chk("vec_busy", {31'b0, busy}, {31'b0, vecs[i].expBusy});
            drain();
        end

        // three GEMVs back-to-back, then exact drain time
        vvt_next = 1'b0;
        fifo.push_back(32'h00000011);
        fifo.push_back(32'h00000022);
        fifo.push_back(32'h00000033);
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gemv3_next", {31'b0, nextLog}, 32'd1);
        end
        chk("gemv3_pending", {26'b0, gemv_pending}, LAT);
        n = 0;
        while (gemv_pending != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("gemv3_drain_cycles", n, LAT);

        // VVT held 5 cycles, next word pops only in the accept cycle
        fifo.push_back(32'h40000ABC);
        fifo.push_back(32'h00000DEF);
        drive();
        tick();
        chk("vvt_hold_pop", {31'b0, nextLog}, 32'd1);
        held = vvt_instruction;
        vvHigh = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("vvt_hold_no_pop", {31'b0, nextLog}, 32'd0);
            chk("vvt_hold_stable", {4'b0, vvt_instruction}, {4'b0, held});
            if (vvSample) vvHigh++;
        end
        vvt_next = 1'b1;
        tick();
        if (vvSample) vvHigh++;
        chk("vvt_hold_accept_pop", {31'b0, nextLog}, 32'd1);
        chk("vvt_hold_cycles", vvHigh, 6);
        chk("vvt_hold_cleared", {31'b0, vvt_valid}, 32'd0);
        drain();

        // GEMV then dependent VVT waits for the full drain
        vvt_next = 1'b0;
        fifo.push_back(32'h00000123);
        fifo.push_back(32'h60000456);
        drive();
        tick();
        n = 0;
        while (!vvt_valid && n < 100) begin
            tick();
            n++;
            if (nextLog) chk("dep_pop_pending", {26'b0, pendSample}, 32'd0);
        end
        chk("dep_latency_bound", {31'b0, n > 0 && n <= LAT + 2}, 32'd1);
        drain();

        // SYNC behind a pending VVT with counter at 12, then EOV
        vvt_next = 1'b0;
        fifo.push_back(32'h00000111);
        fifo.push_back(32'h40000222);
        fifo.push_back(32'h80000000);
        fifo.push_back(32'hC0000000);
        drive();
        tick();
        tick();
        n = 0;
        while (gemv_pending != 12 && n < 60) begin
            tick();
            chk("sync_vvt_wait_no_pop", {31'b0, nextLog}, 32'd0);
            n++;
        end
        chk("sync_reach_12", {26'b0, gemv_pending}, 32'd12);
        vvt_next = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(popped && lastOpc == 2'b10) && n < 60);
        chk("sync_popped", {30'b0, lastOpc}, 32'd2);
        chk("sync_pop_pending", {26'b0, pendSample}, 32'd0);
        chk("sync_pop_vvt", {31'b0, vvSample}, 32'd0);
        tick();
        chk("eov_pop", {30'b0, lastOpc}, 32'd3);
        chk("eov_high", {31'b0, eov_marker}, 32'd1);
        tick();
        chk("eov_low", {31'b0, eov_marker}, 32'd0);
        drain();

        // asynchronous reset while in VVT_WAIT
        vvt_next = 1'b0;
        fifo.push_back(32'h00000AAA);
        fifo.push_back(32'h40000BBB);
        fifo.push_back(32'h00000CCC);
        drive();
        tick();
        tick();
        n = 0;
        while (gemv_pending != 20 && n < 60) begin
            tick();
            n++;
        end
        chk("rst_mid_pending20", {26'b0, gemv_pending}, 32'd20);
        rstn = 1'b0;
        #1;
        chk("rst_mid_vvt_valid", {31'b0, vvt_valid}, 32'd0);
        chk("rst_mid_pending", {26'b0, gemv_pending}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        vvtQ.delete();
        tick();
        tick();
        rstn = 1'b1;
        #1;
        chk("rst_rel_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("rst_rel_pop", {31'b0, nextLog}, 32'd1);
        drain();

        // reload on the cycle the counter would reach zero
        fifo.push_back(32'h00000555);
        drive();
        tick();
        n = 0;
        while (gemv_pending != 1 && n < 60) begin
            tick();
            n++;
        end
        fifo.push_back(32'h00000666);
        drive();
        tick();
        chk("reload_pop", {31'b0, nextLog}, 32'd1);
        chk("reload_pending", {26'b0, gemv_pending}, LAT);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
